// File: rtl/edge_detector_pkg.sv
// Shared edge-detector package.
// Holds the anchor scheduler state encoding, the default anchor column
// advance (STEP) and a helper that derives the last legal anchor column.
// Reused by anchor_scheduler, anchor_counter and gradient_controller.
package edge_detector_pkg;

    // Anchor scheduler FSM states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MOVE,
        S_WAIT,
        S_DONE
    } sched_state_t;

    // Anchor column advance, equal to the number of gradient outputs per window.
    localparam int unsigned DEFAULT_STEP = 14;

    // Largest anchor column x = 1 + k*step that still satisfies
    // x + step + 1 <= img_w - 1. Returns 1 when only the first column fits.
    function automatic int unsigned last_anchor_x(input int unsigned img_w,
                                                  input int unsigned step);
        int unsigned n;
        n = (img_w - 3) / step;
        if (n == 0) begin
            return 1;
        end
        return 1 + (n - 1) * step;
    endfunction

endpackage

// File: rtl/anchor_scheduler_counter.sv
// anchor_counter: anchor position generator for anchor_scheduler.
// Holds the window anchor (x, y), loads (1,1) on init, steps y first and
// wraps y to 1 while advancing x by STEP, and flags the last frame position.
//   clk      in   clock
//   n_rst    in   asynchronous active-low reset (anchor cleared to 0,0)
//   init     in   load anchor (1,1)
//   advance  in   step to the next position
//   x, y     out  current anchor (32-bit unsigned)
//   last     out  anchor is the final position of the frame
module anchor_counter
    import edge_detector_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 48,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init,
    input  logic        advance,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        last
);

    localparam logic [31:0] X_LAST = 32'(last_anchor_x(IMG_W, STEP));
    localparam logic [31:0] Y_LAST = 32'(IMG_H - 2);
    localparam logic [31:0] X_STEP = 32'(STEP);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x <= '0;
            y <= '0;
        end else if (init) begin
            x <= 32'd1;
            y <= 32'd1;
        end else if (advance) begin
            if (y >= Y_LAST) begin
                y <= 32'd1;
                x <= x + X_STEP;
            end else begin
                y <= y + 32'd1;
            end
        end
    end

    assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/anchor_scheduler.sv
// anchor_scheduler: walks the 3x3 window anchor over a frame.
// For each position it requests a window fetch, pulses anchor_moving to
// start the pipeline stages, then waits until every stage has reported
// completion before advancing. Emits frame_done after the last position.
//   clk            in   clock
//   n_rst          in   asynchronous active-low reset
//   start          in   begin a frame scan (honoured in IDLE only)
//   abort          in   synchronous return to IDLE
//   stage_done     in   per-stage completion pulses
//   fetch_req      out  request load of the window at the anchor
//   fetch_ack      in   window loaded
//   anchor_moving  out  one-cycle pulse, anchor changed
//   anchor_x/y     out  window anchor coordinates
//   busy           out  scheduler not idle
//   frame_done     out  one-cycle pulse after the final position
module anchor_scheduler
    import edge_detector_pkg::*;
#(
    parameter int unsigned IMG_W      = 64,
    parameter int unsigned IMG_H      = 48,
    parameter int unsigned STEP       = DEFAULT_STEP,
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  fetch_req,
    input  logic                  fetch_ack,
    output logic                  anchor_moving,
    output logic [31:0]           anchor_x,
    output logic [31:0]           anchor_y,
    output logic                  busy,
    output logic                  frame_done
);

    sched_state_t          state;
    sched_state_t          state_next;
    logic [NUM_STAGES-1:0] mask;
    logic                  mask_full;
    logic                  ctr_init;
    logic                  ctr_advance;
    logic                  at_last;

    anchor_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .STEP  (STEP)
    ) u_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .init    (ctr_init),
        .advance (ctr_advance),
        .x       (anchor_x),
        .y       (anchor_y),
        .last    (at_last)
    );

    // Completion includes pulses arriving in the current cycle.
    assign mask_full = &(mask | stage_done);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mask only accumulates in WAIT; every other state (including MOVE)
    // holds it cleared, so stray pulses outside WAIT never count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mask <= '0;
        end else if (abort || state != S_WAIT) begin
            mask <= '0;
        end else begin
            mask <= mask | stage_done;
        end
    end

    always_comb begin
        state_next  = state;
        ctr_init    = 1'b0;
        ctr_advance = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_FETCH;
                        ctr_init   = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        state_next = S_MOVE;
                    end
                end
                S_MOVE: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (mask_full) begin
                        if (at_last) begin
                            state_next = S_DONE;
                        end else begin
                            state_next  = S_FETCH;
                            ctr_advance = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state only.
    assign fetch_req     = (state == S_FETCH);
    assign anchor_moving = (state == S_MOVE);
    assign frame_done    = (state == S_DONE);
    assign busy          = (state != S_IDLE);

endmodule

// File: doc/anchor_scheduler.md
ANCHOR_SCHEDULER -- requirements
Module: anchor_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 48, image height in pixels.
REQ-003 SHALL have parameter STEP, default 14, anchor column advance, equal to the number of gradient outputs per window.
REQ-004 SHALL have parameter NUM_STAGES, default 3, number of pipeline stages reporting completion.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 n_rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin frame scan; sampled in IDLE only.
REQ-008 abort  input  1  synchronous return to IDLE from any state.
REQ-009 stage_done  input  NUM_STAGES  per-stage completion pulses (filter, gradient, nms finals).
REQ-010 fetch_req  output  1  request to load the window at the current anchor.
REQ-011 fetch_ack  input  1  window data loaded.
REQ-012 anchor_moving  output  1  one-cycle pulse; anchor changed, stages start.
REQ-013 anchor_x  output  32  window column anchor (centre of first 3x3 column).
REQ-014 anchor_y  output  32  window row anchor.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse after the last position completes.

Function
REQ-017 SHALL implement states IDLE, FETCH, MOVE, WAIT, DONE.
REQ-018 IDLE->FETCH when start=1; anchor set to (1,1) on that transition.
REQ-019 FETCH: fetch_req=1 every cycle until, and including, the cycle fetch_ack=1; next state MOVE; fetch_ack outside FETCH ignored.
REQ-020 MOVE: anchor_moving=1 for exactly one cycle; done mask cleared; next state WAIT.
REQ-021 WAIT: a sticky done mask SHALL OR in stage_done each cycle; stage pulses may arrive in any order and cycle.
REQ-022 WAIT exits the cycle after the mask (including same-cycle input) equals all ones: to DONE if at the last position, else advance anchor and go to FETCH.
REQ-023 Advance order: y increments first (inner loop); when y would exceed IMG_H-2, y=1 and x+=STEP.
REQ-024 Valid x values: 1, 1+STEP, ... while x+STEP+1 <= IMG_W-1; the last position is the largest valid x with y=IMG_H-2.
REQ-025 DONE: frame_done=1 for one cycle; next state IDLE; anchor holds its last value.
REQ-026 start while busy SHALL be ignored; start in the same cycle as DONE SHALL NOT restart.
REQ-027 abort has priority over all transitions; it clears mask and drives fetch_req=0 and anchor_moving=0 next cycle; frame_done not pulsed; anchor holds.
REQ-028 stage_done pulses in IDLE, FETCH, DONE SHALL be ignored; a pulse in the MOVE cycle SHALL be ignored (mask cleared).
REQ-029 Coordinate arithmetic unsigned 32-bit; no wrap occurs for legal parameters (IMG_W >= STEP+2, IMG_H >= 3).
REQ-030 Outputs fetch_req, anchor_moving, frame_done, busy SHALL be registered or decoded from the registered state only; no input-to-output combinational path.

Reset
REQ-031 On n_rst=0: state IDLE, anchor_x=0, anchor_y=0, mask=0, fetch_req=0, anchor_moving=0, frame_done=0, busy=0.
REQ-032 Reset mid-scan SHALL abandon the frame without a frame_done pulse; the first scan after reset starts at (1,1).

Structure
REQ-033 State enum and a STEP constant default SHALL live in the shared edge-detector package, reused by gradient_controller.
REQ-034 The anchor position generator (x/y counters, last-position detect) SHALL be one sub-module, anchor_counter; no other sub-modules.

Verification (IMG_W=32, IMG_H=5, STEP=14, NUM_STAGES=3 unless stated)
REQ-035 Full frame, ack after 2 cycles, all done bits same cycle -> 6 anchor_moving pulses at (1,1),(1,2),(1,3),(15,1),(15,2),(15,3), then one frame_done, busy=0.
REQ-036 Done bits staggered 1,4,9 cycles after MOVE -> exit WAIT exactly one cycle after bit 9 arrives; no early FETCH.
REQ-037 fetch_ack held low 20 cycles -> fetch_req high all 20+1 cycles, single anchor_moving afterwards.
REQ-038 abort in WAIT at (15,2) -> IDLE next cycle, no frame_done; a following start restarts at (1,1).
REQ-039 n_rst pulsed in FETCH -> all outputs zero immediately; start while busy ignored; stage_done in IDLE has no effect.
REQ-040 Default parameters (64x48) -> 184 anchor_moving pulses, last at (43,46).
